load_store_unit: RTL and testbench

Memory-access back end for the single-issue RV32I core. It consumes the memory control fields produced by the main decoder: `mem_read` size, `mem_write`, and the signed/unsigned select. It turns them into one request/response transaction on the data bus, with byte-lane steering, alignment checking and load sign/zero extension. It sits between execute (which supplies the effective address and store data) and writeback (which takes the aligned load result), and stalls the pipeline while a transaction is in flight.

---
 rtl/load_store_unit_if.sv | 22 ++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-bus request/response channel between the load/store unit (master)
// and the memory system (slave).
interface load_store_unit_if #(parameter int ADDR_W = 32);
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_wdata;
  logic              bus_resp_valid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
    input  bus_req_ready, bus_resp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
    output bus_req_ready, bus_resp_valid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store back end: one bus transaction per op, with lane steering,
// alignment checking and load extension.
//
// state | meaning
// IDLE  | waiting for a memory op from execute
// REQ   | bus request presented, waiting for ready
// WAIT  | request accepted, waiting for response
// DONE  | one-cycle completion pulse to writeback
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        mem_read,
  input  logic              mem_write,
  input  logic [1:0]        store_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  load_store_unit_if.master bus,
  output logic              lsu_done,
  output logic [DATA_W-1:0] load_data,
  output logic              misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsuState_t;

  lsuState_t         state, nextState;
  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        sizeQ;
  logic              unsignedQ;
  logic              writeQ;
  logic [DATA_W-1:0] storeDataQ;
  logic [DATA_W-1:0] loadDataQ;
  logic              misalignQ;

  logic              accept;
  logic              badOp;
  logic [1:0]        opSize;
  logic [1:0]        lane;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] extracted;

  assign opSize = mem_write ? store_size : mem_read;
  assign accept = (state == IDLE) && op_valid && ((mem_read != 2'b00) || mem_write);

  // Read+write together is illegal; it shares the no-bus path with misalignment.
  assign badOp = ((mem_read != 2'b00) && mem_write)
              || ((opSize == 2'b10) && addr[0])
              || ((opSize == 2'b11) && (addr[1:0] != 2'b00));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState         = state;
    busy              = 1'b1;
    bus.bus_req_valid = 1'b0;
    lsu_done          = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) nextState = badOp ? DONE : REQ;
      end
      REQ: begin
        bus.bus_req_valid = 1'b1;
        if (bus.bus_req_ready) nextState = WAIT;
      end
      WAIT: begin
        if (bus.bus_resp_valid) nextState = DONE;
      end
      DONE: begin
        lsu_done  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign lane    = addrQ[1:0];
  assign shifted = bus.bus_rdata >> {lane, 3'b000};

  always_comb begin
    case (sizeQ)
      2'b01:   extracted = {{24{~unsignedQ & shifted[7]}}, shifted[7:0]};
      2'b10:   extracted = {{16{~unsignedQ & shifted[15]}}, shifted[15:0]};
      default: extracted = shifted;
    endcase
  end

  // Request fields come only from latched state, so they hold through back-pressure.
  always_comb begin
    bus.bus_wstrb = 4'b0000;
    if (writeQ) begin
      case (sizeQ)
        2'b01:   bus.bus_wstrb = 4'b0001 << lane;
        2'b10:   bus.bus_wstrb = 4'b0011 << lane;
        2'b11:   bus.bus_wstrb = 4'b1111;
        default: bus.bus_wstrb = 4'b0000;
      endcase
    end
    case (sizeQ)
      2'b01:   bus.bus_wdata = {4{storeDataQ[7:0]}};
      2'b10:   bus.bus_wdata = {2{storeDataQ[15:0]}};
      default: bus.bus_wdata = storeDataQ;
    endcase
  end

  assign bus.bus_addr = {addrQ[ADDR_W-1:2], 2'b00};
  assign bus.bus_we   = writeQ;
  assign load_data    = loadDataQ;
  assign misalign     = misalignQ;

  always_ff @(posedge clock) begin
    if (reset) begin
      addrQ      <= '0;
      sizeQ      <= 2'b00;
      unsignedQ  <= 1'b0;
      writeQ     <= 1'b0;
      storeDataQ <= '0;
      loadDataQ  <= '0;
      misalignQ  <= 1'b0;
    end else if (accept) begin
      addrQ      <= addr;
      sizeQ      <= opSize;
      unsignedQ  <= mem_unsigned;
      writeQ     <= mem_write;
      storeDataQ <= store_data;
      loadDataQ  <= '0;
      misalignQ  <= badOp;
    end else if ((state == WAIT) && bus.bus_resp_valid && !writeQ) begin
      loadDataQ  <= extracted;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level
// reference model of the load/store rules.
module tb_load_store_unit;
  logic        clock;
  logic        reset;
  logic        op_valid;
  logic [1:0]  mem_read;
  logic        mem_write;
  logic [1:0]  store_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        lsu_done;
  logic [31:0] load_data;
  logic        misalign;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .mem_read(mem_read),
    .mem_write(mem_write), .store_size(store_size), .mem_unsigned(mem_unsigned),
    .addr(addr), .store_data(store_data), .busy(busy), .bus(bus),
    .lsu_done(lsu_done), .load_data(load_data), .misalign(misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Byte-level view: an access touches n = 1/2/4 bytes starting at lane addr%4.
  function automatic void refModel(
    input  logic [1:0] rd, input logic wr, input logic [1:0] ss, input logic uns,
    input  logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
    output bit mis, output logic [3:0] strb, output logic [31:0] wdat, output logic [31:0] ld);
    int n, k;
    longint v;
    k = int'(a % 4);
    n = wr ? ((1 << ss) >> 1) : ((1 << rd) >> 1);
    mis = ((rd != 2'b00) && wr) || ((n > 0) && ((k % n) != 0));
    strb = 4'b0000;
    wdat = 32'h0;
    ld = 32'h0;
    if (!mis && wr && n > 0) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= k && i < k + n) strb[i] = 1'b1;
        wdat[8*i +: 8] = sd[8*(i % n) +: 8];
      end
    end
    if (!mis && !wr && n > 0) begin
      v = 0;
      for (int j = 0; j < n; j++) v += longint'(rdat[8*(k+j) +: 8]) << (8*j);
      if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
      ld = v[31:0];
    end
  endfunction

  task automatic checkResetValues(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_req_valid"}, bus.bus_req_valid, 0);
    check({tag, "_we"},        bus.bus_we, 0);
    check({tag, "_wstrb"},     bus.bus_wstrb, 0);
    check({tag, "_addr"},      bus.bus_addr, 0);
    check({tag, "_wdata"},     bus.bus_wdata, 0);
    check({tag, "_load_data"}, load_data, 0);
    check({tag, "_done"},      lsu_done, 0);
    check({tag, "_misalign"},  misalign, 0);
  endtask

  task automatic driveJunk(input bit hammer);
    op_valid     = hammer;
    mem_read     = 2'b11;
    mem_write    = 1'b0;
    store_size   = 2'($urandom_range(0, 3));
    mem_unsigned = 1'($urandom_range(0, 1));
    addr         = {$urandom_range(0, 32'h3FFF_FFFF), 2'b10};
    store_data   = $urandom;
  endtask

  task automatic doOp(
    input string tag, input logic [1:0] rd, input logic wr, input logic [1:0] ss,
    input logic uns, input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
    input int readyDly, input int respDly, input bit hammer, output logic [31:0] obsLoad);
    bit mis;
    logic [3:0] strb;
    logic [31:0] wdat, ld;
    refModel(rd, wr, ss, uns, a, sd, rdat, mis, strb, wdat, ld);
    @(negedge clock);
    check({tag, "_idle"}, busy, 0);
    op_valid = 1'b1; mem_read = rd; mem_write = wr; store_size = ss;
    mem_unsigned = uns; addr = a; store_data = sd;
    @(posedge clock); #1;
    driveJunk(hammer);
    if (mis) begin
      @(negedge clock);
      check({tag, "_mis_done"}, lsu_done, 1);
      check({tag, "_mis_flag"}, misalign, 1);
      check({tag, "_mis_ld"},   load_data, 0);
      check({tag, "_mis_noreq"}, bus.bus_req_valid, 0);
      obsLoad = load_data;
      @(posedge clock); #1;
    end else begin
      for (int i = 0; i <= readyDly; i++) begin
        @(negedge clock);
        check({tag, "_req_valid"}, bus.bus_req_valid, 1);
        check({tag, "_req_busy"},  busy, 1);
        check({tag, "_req_addr"},  bus.bus_addr, a & 32'hFFFF_FFFC);
        check({tag, "_req_we"},    bus.bus_we, wr);
        check({tag, "_req_wstrb"}, bus.bus_wstrb, strb);
        if (wr) check({tag, "_req_wdata"}, bus.bus_wdata, wdat);
        if (i == readyDly) bus.bus_req_ready = 1'b1;
        @(posedge clock); #1;
        bus.bus_req_ready = 1'b0;
      end
      for (int i = 0; i <= respDly; i++) begin
        @(negedge clock);
        check({tag, "_wait_busy"},  busy, 1);
        check({tag, "_wait_noreq"}, bus.bus_req_valid, 0);
        check({tag, "_wait_nodone"}, lsu_done, 0);
        if (i == respDly) begin
          bus.bus_resp_valid = 1'b1;
          bus.bus_rdata = rdat;
        end
        @(posedge clock); #1;
        bus.bus_resp_valid = 1'b0;
        bus.bus_rdata = $urandom;
      end
      @(negedge clock);
      check({tag, "_done"},      lsu_done, 1);
      check({tag, "_misalign"},  misalign, 0);
      check({tag, "_load_data"}, load_data, ld);
      obsLoad = load_data;
      @(posedge clock); #1;
    end
    @(negedge clock);
    check({tag, "_after_done"}, lsu_done, 0);
    check({tag, "_after_busy"}, busy, 0);
    op_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] obs;
    logic [1:0] rd, ss;
    logic wr;
    int kind;

    reset = 1'b1; op_valid = 1'b0; mem_read = 2'b00; mem_write = 1'b0;
    store_size = 2'b00; mem_unsigned = 1'b0; addr = 32'h0; store_data = 32'h0;
    bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0; bus.bus_rdata = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkResetValues("reset");
    reset = 1'b0;

    doOp("lw", 2'b11, 0, 2'b00, 0, 32'h1000_0008, 32'h0, 32'hDEADBEEF, 0, 0, 0, obs);
    check("lw_known", obs, 32'hDEADBEEF);
    doOp("lb", 2'b01, 0, 2'b00, 0, 32'h1000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0, obs);
    check("lb_known", obs, 32'hFFFF_FF80);
    doOp("lbu", 2'b01, 0, 2'b00, 1, 32'h1000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0, obs);
    check("lbu_known", obs, 32'h0000_0080);
    doOp("lh", 2'b10, 0, 2'b00, 0, 32'h1000_0002, 32'h0, 32'h80FF_1234, 0, 0, 0, obs);
    check("lh_known", obs, 32'hFFFF_80FF);
    doOp("sb", 2'b00, 1, 2'b01, 0, 32'h1000_0001, 32'h0000_00AB, $urandom, 0, 0, 0, obs);
    doOp("sh", 2'b00, 1, 2'b10, 0, 32'h1000_0002, 32'h0000_1234, $urandom, 0, 0, 0, obs);
    doOp("lw_mis", 2'b11, 0, 2'b00, 0, 32'h1000_0002, 32'h0, $urandom, 0, 0, 0, obs);
    doOp("sh_mis", 2'b00, 1, 2'b10, 0, 32'h1000_0003, 32'h5555_1234, $urandom, 0, 0, 0, obs);
    doOp("illegal", 2'b01, 1, 2'b01, 0, 32'h1000_0000, 32'h0, $urandom, 0, 0, 0, obs);
    doOp("bp_sw", 2'b00, 1, 2'b11, 0, 32'h3000_0010, 32'hCAFE_F00D, $urandom, 4, 3, 1, obs);
    doOp("bp_lhu", 2'b10, 0, 2'b00, 1, 32'h3000_0016, 32'h0, 32'h9ABC_1357, 4, 3, 1, obs);

    // An op_valid with neither read nor write must not start anything.
    @(negedge clock);
    op_valid = 1'b1; mem_read = 2'b00; mem_write = 1'b0; addr = 32'h4000_0000;
    @(posedge clock); #1;
    op_valid = 1'b0;
    @(negedge clock);
    check("nop_busy", busy, 0);

    // Reset while waiting for the response drops the transaction.
    @(negedge clock);
    op_valid = 1'b1; mem_read = 2'b11; mem_write = 1'b0; addr = 32'h2000_0004;
    @(posedge clock); #1;
    op_valid = 1'b0;
    @(negedge clock);
    bus.bus_req_ready = 1'b1;
    @(posedge clock); #1;
    bus.bus_req_ready = 1'b0;
    @(negedge clock);
    check("rst_pre_busy", busy, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkResetValues("rst_wait");
    bus.bus_resp_valid = 1'b1; bus.bus_rdata = 32'h1234_5678;
    @(posedge clock); #1;
    bus.bus_resp_valid = 1'b0;
    @(negedge clock);
    check("rst_late_done", lsu_done, 0);
    check("rst_late_busy", busy, 0);
    @(negedge clock);
    check("rst_late_done2", lsu_done, 0);
    doOp("post_rst_lw", 2'b11, 0, 2'b00, 0, 32'h2000_0008, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, obs);

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      rd = 2'b00; wr = 1'b0; ss = 2'($urandom_range(0, 3));
      if (kind < 5) rd = 2'($urandom_range(1, 3));
      else if (kind < 9) begin wr = 1'b1; ss = 2'($urandom_range(1, 3)); end
      else begin rd = 2'($urandom_range(1, 3)); wr = 1'b1; end
      doOp("rand", rd, wr, ss, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), obs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
